mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_load_align.sv | 35 +++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Memory stage shared types: bus payload layouts, widths and FSM state encoding.
// Imported by the interface, the load aligner and the mem_stage top.
package mem_stage_pkg;

   localparam int unsigned DATA_WD              = 32;
   localparam int unsigned REG_AW               = 5;
   localparam int unsigned ES_TO_MS_BUS_WD      = 76;
   localparam int unsigned MS_TO_WS_BUS_WD      = 71;
   localparam int unsigned MS_TO_DS_FORWARD_BUS = 39;

   // Execute -> memory payload, msb first: {sign_ext, excp, mem_size, store_op, load_op, gr_we, dest, result, pc}
   typedef struct packed {
      logic                sign_ext;
      logic                excp;
      logic [1:0]          mem_size;
      logic                store_op;
      logic                load_op;
      logic                gr_we;
      logic [REG_AW-1:0]   dest;
      logic [DATA_WD-1:0]  result;
      logic [DATA_WD-1:0]  pc;
   } es_to_ms_bus_t;

   // Memory -> writeback payload: {excp, gr_we, dest, final_result, pc}
   typedef struct packed {
      logic                excp;
      logic                gr_we;
      logic [REG_AW-1:0]   dest;
      logic [DATA_WD-1:0]  final_result;
      logic [DATA_WD-1:0]  pc;
   } ms_to_ws_bus_t;

   // Memory -> decode forwarding payload: {dep_need_stall, forward_enable, dest, final_result}
   typedef struct packed {
      logic                dep_need_stall;
      logic                forward_enable;
      logic [REG_AW-1:0]   dest;
      logic [DATA_WD-1:0]  final_result;
   } ms_to_ds_fwd_t;

   // IDLE: nothing owed; WAIT: response outstanding; HOLD: response captured,
   // writeback stalled; DROP: response outstanding for a flushed instruction.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } ms_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake/bus bundle around the memory stage.
// slave : the memory stage's view (execute/writeback/cache inputs, stage outputs).
// master: the surrounding pipeline's view (drives inputs, observes outputs).
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                es_to_ms_valid;
   es_to_ms_bus_t       es_to_ms_bus;
   logic                ms_allowin;
   logic                ws_allowin;
   logic                ms_to_ws_valid;
   ms_to_ws_bus_t       ms_to_ws_bus;
   ms_to_ds_fwd_t       ms_to_ds_forward_bus;
   logic                data_data_ok;
   logic [DATA_WD-1:0]  data_rdata;
   logic                excp_flush;
   logic                ms_flush;

   modport slave (
      input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata, excp_flush,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_flush
   );

   modport master (
      output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata, excp_flush,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_flush
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational byte/halfword lane select and sign/zero extension.
// Ports: raw (32b word from cache or hold register), addr_lo (address bits [1:0]),
//        mem_size ([0]=byte, [1]=half, 00=word), sign_ext, aligned_c (extended load data).
module load_align
   import mem_stage_pkg::*;
(
   input  logic [DATA_WD-1:0] raw,
   input  logic [1:0]         addr_lo,
   input  logic [1:0]         mem_size,
   input  logic               sign_ext,
   output logic [DATA_WD-1:0] aligned_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select and extension
   always_comb begin
      byte_sel  = raw[7:0];
      half_sel  = addr_lo[1] ? raw[31:16] : raw[15:0];
      aligned_c = raw;
      case (addr_lo)
         2'd0:    byte_sel = raw[7:0];
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         default: byte_sel = raw[31:24];
      endcase
      if (mem_size[0]) begin
         aligned_c = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end else if (mem_size[1]) begin
         aligned_c = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Tracks the one outstanding data-cache response
// per memory instruction, holds load data while writeback stalls, and discards the
// response of a flushed instruction.
// Ports: clk, reset (sync, active-high), bus (mem_stage_if.slave: execute handshake,
//        writeback handshake, decode forwarding, cache response, flush in/out).
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   mem_stage_if.slave   bus
);

   ms_state_e           state;
   ms_state_e           state_nxt;
   logic                capture;
   logic                ms_valid;
   es_to_ms_bus_t       ms_bus;
   logic [DATA_WD-1:0]  hold_data;

   logic                mem_access;
   logic                ms_ready_go;
   logic                allowin;
   logic                accept;
   logic                accept_mem;
   logic [DATA_WD-1:0]  load_raw;
   logic [DATA_WD-1:0]  load_data;
   logic [DATA_WD-1:0]  final_result;

   // Handshake; DROP blocks intake until the stale response has drained
   assign mem_access  = (ms_bus.load_op | ms_bus.store_op) & ~ms_bus.excp;
   assign ms_ready_go = ~mem_access
                      | ((state == ST_WAIT) & bus.data_data_ok)
                      | (state == ST_HOLD);
   assign allowin     = (state != ST_DROP) & (~ms_valid | (ms_ready_go & bus.ws_allowin));
   assign accept      = bus.es_to_ms_valid & allowin;
   // An instruction accepted under flush is killed, so it never owns a response
   assign accept_mem  = accept & ~bus.excp_flush & ~bus.es_to_ms_bus.excp
                      & (bus.es_to_ms_bus.load_op | bus.es_to_ms_bus.store_op);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state; a new memory op accepted as the current one retires re-enters WAIT
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept_mem) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.data_data_ok) begin
               if (bus.excp_flush) begin
                  state_nxt = ST_IDLE;
               end else if (bus.ws_allowin) begin
                  state_nxt = accept_mem ? ST_WAIT : ST_IDLE;
               end else begin
                  state_nxt = ST_HOLD;
                  capture   = 1'b1;
               end
            end else if (bus.excp_flush) begin
               state_nxt = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (bus.excp_flush)      state_nxt = ST_IDLE;
            else if (bus.ws_allowin) state_nxt = accept_mem ? ST_WAIT : ST_IDLE;
         end
         ST_DROP: begin
            if (bus.data_data_ok) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage valid, payload and captured load word
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid  <= 1'b0;
         ms_bus    <= '0;
         hold_data <= '0;
      end else begin
         if (bus.excp_flush) ms_valid <= 1'b0;
         else if (allowin)   ms_valid <= bus.es_to_ms_valid;
         if (accept)  ms_bus    <= bus.es_to_ms_bus;
         if (capture) hold_data <= bus.data_rdata;
      end
   end

   assign load_raw = (state == ST_HOLD) ? hold_data : bus.data_rdata;

   load_align u_load_align (
      .raw       (load_raw),
      .addr_lo   (ms_bus.result[1:0]),
      .mem_size  (ms_bus.mem_size),
      .sign_ext  (ms_bus.sign_ext),
      .aligned_c (load_data)
   );

   assign final_result = ms_bus.load_op ? load_data : ms_bus.result;

   // Outputs
   assign bus.ms_allowin     = allowin;
   assign bus.ms_to_ws_valid = ms_valid & ms_ready_go;
   assign bus.ms_flush       = ms_valid & ms_bus.excp;
   assign bus.ms_to_ws_bus   = '{excp:         ms_bus.excp,
                                 gr_we:        ms_bus.gr_we,
                                 dest:         ms_bus.dest,
                                 final_result: final_result,
                                 pc:           ms_bus.pc};
   assign bus.ms_to_ds_forward_bus = '{
      dep_need_stall: ms_valid & ms_bus.load_op & ~ms_ready_go,
      forward_enable: ms_valid & ms_bus.gr_we & (ms_bus.dest != '0),
      dest:           ms_bus.dest,
      final_result:   final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writeback payloads
// pushed at acceptance, popped on each writeback transfer.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   ms_to_ws_bus_t exp_q[$];
   ms_to_ws_bus_t exp_e;

   always #5 clk = ~clk;

   mem_stage_if ifc ();

   mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic es_to_ms_bus_t mk(input logic ld, input logic st, input logic ex,
                                        input logic sext, input logic [1:0] sz, input logic we,
                                        input logic [4:0] dst, input logic [31:0] res,
                                        input logic [31:0] pc);
      es_to_ms_bus_t b;
      b.sign_ext = sext; b.excp = ex; b.mem_size = sz; b.store_op = st; b.load_op = ld;
      b.gr_we = we; b.dest = dst; b.result = res; b.pc = pc;
      return b;
   endfunction

   function automatic ms_to_ws_bus_t exp_ws(input es_to_ms_bus_t b, input logic [31:0] fin);
      ms_to_ws_bus_t w;
      w.excp = b.excp; w.gr_we = b.gr_we; w.dest = b.dest; w.final_result = fin; w.pc = b.pc;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Present one instruction, wait (bounded) for acceptance, optionally expect it downstream
   task automatic send(input es_to_ms_bus_t b, input logic [31:0] fin, input bit expect_out);
      int n;
      n = 0;
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = b;
      @(negedge clk);
      while (!ifc.ms_allowin && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept", 128'(ifc.ms_allowin), 128'(1));
      if (expect_out) exp_q.push_back(exp_ws(b, fin));
      step();
      ifc.es_to_ms_valid = 1'b0;
   endtask

   // Writeback transfer monitor; transfers under flush or reset are not real
   always @(negedge clk) begin
      if (!reset && ifc.ms_to_ws_valid && ifc.ws_allowin && !ifc.excp_flush) begin
         if (exp_q.size() == 0) begin
            check_eq("ws_unexpected", 128'(exp_q.size()), 128'(1));
         end else begin
            exp_e = exp_q.pop_front();
            check_eq("ws_bus", 128'(ifc.ms_to_ws_bus), 128'(exp_e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      es_to_ms_bus_t add_b;
      reset = 1'b1;
      ifc.es_to_ms_valid = 1'b0;
      ifc.es_to_ms_bus   = '0;
      ifc.ws_allowin     = 1'b1;
      ifc.data_data_ok   = 1'b0;
      ifc.data_rdata     = '0;
      ifc.excp_flush     = 1'b0;
      repeat (2) step();
      reset = 1'b0;

      // Reset state
      mid();
      check_eq("rst_ws_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      check_eq("rst_allowin", 128'(ifc.ms_allowin), 128'(1));
      check_eq("rst_fwd_bus", 128'(ifc.ms_to_ds_forward_bus), 128'(0));
      check_eq("rst_flush", 128'(ifc.ms_flush), 128'(0));
      step();

      // ld.b sign-extended, lane 3
      send(mk(1, 0, 0, 1, 2'b01, 1, 5'd3, 32'h0000_1003, 32'h100), 32'hFFFF_FF80, 1);
      mid();
      check_eq("ldb_dep_stall", 128'(ifc.ms_to_ds_forward_bus.dep_need_stall), 128'(1));
      check_eq("ldb_wait_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h80FF_FF00;
      mid();
      check_eq("ldb_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      check_eq("ldb_fwd_result", 128'(ifc.ms_to_ds_forward_bus.final_result), 128'(32'hFFFF_FF80));
      step();
      ifc.data_data_ok = 1'b0; ifc.data_rdata = '0;

      // ld.hu with writeback stalled three cycles
      send(mk(1, 0, 0, 0, 2'b10, 1, 5'd4, 32'h0000_2002, 32'h104), 32'h0000_BEEF, 1);
      ifc.ws_allowin = 1'b0; ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'hBEEF_1234;
      mid();
      check_eq("ldhu_result", 128'(ifc.ms_to_ds_forward_bus.final_result), 128'(32'h0000_BEEF));
      step();
      ifc.data_data_ok = 1'b0; ifc.data_rdata = 32'hDEAD_DEAD;
      for (int i = 0; i < 2; i++) begin
         mid();
         check_eq("hold_state", 128'(dut.state), 128'(ST_HOLD));
         check_eq("hold_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
         check_eq("hold_result", 128'(ifc.ms_to_ds_forward_bus.final_result), 128'(32'h0000_BEEF));
         step();
      end
      ifc.ws_allowin = 1'b1;
      mid();
      check_eq("hold_release", 128'(ifc.ms_to_ws_valid), 128'(1));
      step();
      mid();
      check_eq("post_release_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.data_rdata = '0;

      // ld.w flushed while waiting: DROP until the stale response arrives
      add_b = mk(0, 0, 0, 0, 2'b00, 1, 5'd5, 32'h0000_1234, 32'h10C);
      send(mk(1, 0, 0, 0, 2'b00, 1, 5'd6, 32'h0000_3000, 32'h108), 32'h0, 0);
      ifc.excp_flush = 1'b1;
      mid();
      check_eq("flush_wait_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.excp_flush = 1'b0;
      ifc.es_to_ms_valid = 1'b1; ifc.es_to_ms_bus = add_b;
      mid();
      check_eq("drop_allowin_a", 128'(ifc.ms_allowin), 128'(0));
      check_eq("drop_valid_a", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'hCAFE_F00D;
      mid();
      check_eq("drop_allowin_b", 128'(ifc.ms_allowin), 128'(0));
      check_eq("drop_valid_b", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.data_data_ok = 1'b0; ifc.data_rdata = '0;
      send(add_b, 32'h0000_1234, 1);
      mid();
      check_eq("add_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      check_eq("add_fwd_en", 128'(ifc.ms_to_ds_forward_bus.forward_enable), 128'(1));
      check_eq("add_dep_stall", 128'(ifc.ms_to_ds_forward_bus.dep_need_stall), 128'(0));
      step();

      // Flush coinciding with the response: no DROP, next load's data kept
      send(mk(1, 0, 0, 0, 2'b00, 1, 5'd7, 32'h0000_4000, 32'h110), 32'h0, 0);
      ifc.excp_flush = 1'b1; ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h1111_1111;
      step();
      ifc.excp_flush = 1'b0; ifc.data_data_ok = 1'b0;
      mid();
      check_eq("noDrop_allowin", 128'(ifc.ms_allowin), 128'(1));
      check_eq("noDrop_state", 128'(dut.state), 128'(ST_IDLE));
      step();
      send(mk(1, 0, 0, 0, 2'b00, 1, 5'd8, 32'h0000_4004, 32'h114), 32'h55AA_1234, 1);
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h55AA_1234;
      mid();
      check_eq("next_ld_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      step();
      ifc.data_data_ok = 1'b0;

      // Load to r0: no forwarding
      send(mk(1, 0, 0, 0, 2'b00, 1, 5'd0, 32'h0000_5000, 32'h118), 32'h1234_5678, 1);
      mid();
      check_eq("r0_fwd_en", 128'(ifc.ms_to_ds_forward_bus.forward_enable), 128'(0));
      check_eq("r0_dep_stall", 128'(ifc.ms_to_ds_forward_bus.dep_need_stall), 128'(1));
      step();
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h1234_5678;
      step();
      ifc.data_data_ok = 1'b0;

      // Store: completes on response, result passes through
      send(mk(0, 1, 0, 0, 2'b00, 0, 5'd0, 32'h0000_6000, 32'h11C), 32'h0000_6000, 1);
      mid();
      check_eq("st_wait_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      step();
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'hFFFF_FFFF;
      mid();
      check_eq("st_done_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      step();
      ifc.data_data_ok = 1'b0; ifc.data_rdata = '0;

      // Excepting store: passes in one cycle, raises ms_flush
      send(mk(0, 1, 1, 0, 2'b00, 0, 5'd0, 32'h0000_7777, 32'h120), 32'h0000_7777, 1);
      mid();
      check_eq("excp_ms_flush", 128'(ifc.ms_flush), 128'(1));
      check_eq("excp_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      step();

      // Back-to-back: ld.bu retires while ld.h is accepted
      send(mk(1, 0, 0, 0, 2'b01, 1, 5'd9, 32'h0000_7001, 32'h124), 32'h0000_00AB, 1);
      ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h0000_AB00;
      send(mk(1, 0, 0, 1, 2'b10, 1, 5'd10, 32'h0000_7002, 32'h128), 32'hFFFF_8001, 1);
      ifc.data_rdata = 32'h8001_0000;
      mid();
      check_eq("b2b_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
      step();
      ifc.data_data_ok = 1'b0; ifc.data_rdata = '0;

      // Reset while waiting overrides flush and response
      send(mk(1, 0, 0, 0, 2'b00, 1, 5'd11, 32'h0000_8000, 32'h12C), 32'h0, 0);
      reset = 1'b1; ifc.data_data_ok = 1'b1; ifc.excp_flush = 1'b1;
      step();
      reset = 1'b0; ifc.data_data_ok = 1'b0; ifc.excp_flush = 1'b0;
      mid();
      check_eq("wrst_state", 128'(dut.state), 128'(ST_IDLE));
      check_eq("wrst_ws_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
      check_eq("wrst_allowin", 128'(ifc.ms_allowin), 128'(1));
      check_eq("wrst_fwd_bus", 128'(ifc.ms_to_ds_forward_bus), 128'(0));
      check_eq("wrst_ws_bus", 128'(ifc.ms_to_ws_bus), 128'(0));
      check_eq("wrst_flush", 128'(ifc.ms_flush), 128'(0));
      step();

      check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
